// File: rtl/wallace_mac_accum.sv
// wallace_mac_accum: sequenced multiply-accumulate tile behind the 4x4 Wallace multiplier.
// Sums a programmed number of unsigned product beats into a saturating accumulator,
// then holds the result under a valid/ready handshake until the consumer takes it.
module wallace_mac_accum #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   n_lat_q;

  // One guard bit above the accumulator exposes overflow of the unsigned add.
  logic [ACC_W:0]     sum_ext;
  logic [CNT_W-1:0]   cnt_inc;

  // Next-sum and next-count datapath; only latched when a beat is taken.
  always_comb begin
    sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    cnt_inc = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    in_ready  = ena && (state_q == StAccum);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    acc_out   = acc_q;
    ovf       = ovf_q;
  end

  // Control FSM and accumulator; ena low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      n_lat_q <= '0;
    end else if (ena) begin
      case (state_q)
        StIdle: begin
          if (start) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            n_lat_q <= n_terms;
            state_q <= (n_terms != '0) ? StAccum : StDone;
          end
        end
        StAccum: begin
          // in_ready equals ena here, so a beat is simply in_valid.
          if (in_valid) begin
            if (sum_ext[ACC_W]) begin
              acc_q <= '1;
              ovf_q <= 1'b1;
            end else begin
              acc_q <= sum_ext[ACC_W-1:0];
            end
            cnt_q <= cnt_inc;
            if (cnt_inc == n_lat_q) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          // start is intentionally ignored here, even alongside out_ready.
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_mac_accum.sv
// Self-checking bench for wallace_mac_accum: table of accumulation runs plus directed
// sequences for saturation, stalls, zero-length runs, enable freeze and async reset.
module tb_wallace_mac_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [7:0]  n_terms;
  logic [7:0]  in_prod;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready;
  logic [15:0] acc_out;
  logic        ovf;
  logic        out_valid;
  logic        busy;

  logic        in_ready10;
  logic [9:0]  acc_out10;
  logic        ovf10;
  logic        out_valid10;
  logic        busy10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wallace_mac_accum #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .n_terms(n_terms),
    .in_prod(in_prod), .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  // Narrow accumulator copy sharing the same stimulus, used for saturation.
  wallace_mac_accum #(.PROD_W(8), .ACC_W(10), .CNT_W(8)) dut10 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .n_terms(n_terms),
    .in_prod(in_prod), .in_valid(in_valid), .in_ready(in_ready10), .acc_out(acc_out10),
    .ovf(ovf10), .out_valid(out_valid10), .out_ready(out_ready), .busy(busy10)
  );

  typedef struct {
    logic [7:0]       n;
    logic [0:3][7:0]  p;
    logic [15:0]      acc;
    logic             ovf;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    n_terms = n;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] p);
    in_valid = 1'b1;
    in_prod = p;
    tick();
    in_valid = 1'b0;
    in_prod = 8'd0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    vec[0] = '{n: 8'd3, p: '{8'd225, 8'd225, 8'd225, 8'd0}, acc: 16'd675,  ovf: 1'b0};
    vec[1] = '{n: 8'd1, p: '{8'd9,   8'd0,   8'd0,   8'd0}, acc: 16'd9,    ovf: 1'b0};
    vec[2] = '{n: 8'd4, p: '{8'd255, 8'd255, 8'd255, 8'd255}, acc: 16'd1020, ovf: 1'b0};
    vec[3] = '{n: 8'd2, p: '{8'd0,   8'd0,   8'd0,   8'd0}, acc: 16'd0,    ovf: 1'b0};
    vec[4] = '{n: 8'd0, p: '{8'd0,   8'd0,   8'd0,   8'd0}, acc: 16'd0,    ovf: 1'b0};
    vec[5] = '{n: 8'd4, p: '{8'd1,   8'd2,   8'd3,   8'd4}, acc: 16'd10,   ovf: 1'b0};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; n_terms = 8'd0;
    in_prod = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset_acc", acc_out, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Table-driven runs, beats back to back.
    for (int v = 0; v < NVEC; v++) begin
      do_start(vec[v].n);
      chk("run_busy", busy, 1);
      for (int b = 0; b < int'(vec[v].n); b++) begin
        in_valid = 1'b1;
        in_prod = vec[v].p[b];
        #1;
        chk("run_in_ready", in_ready, 1);
        chk("run_out_valid_early", out_valid, 0);
        tick();
      end
      in_valid = 1'b0;
      chk("run_out_valid", out_valid, 1);
      chk("run_acc", acc_out, 32'(vec[v].acc));
      chk("run_ovf", ovf, 32'(vec[v].ovf));
      chk("run_in_ready_done", in_ready, 0);
      release_result();
      chk("run_idle_out_valid", out_valid, 0);
      chk("run_idle_busy", busy, 0);
      chk("run_idle_acc_kept", acc_out, 32'(vec[v].acc));
    end

    // Saturation on the 10-bit accumulator: 225*5 = 1125 > 1023.
    do_start(8'd5);
    for (int k = 1; k <= 4; k++) begin
      beat(8'd225);
      chk("sat_acc_partial", acc_out10, 32'(225 * k));
      chk("sat_ovf_partial", ovf10, 0);
    end
    beat(8'd225);
    chk("sat_acc", acc_out10, 1023);
    chk("sat_ovf", ovf10, 1);
    chk("sat_out_valid", out_valid10, 1);
    chk("sat_wide_acc", acc_out, 1125);
    release_result();
    chk("sat_ovf_kept_idle", ovf10, 1);

    // Bubbles between beats, then a stalled consumer.
    do_start(8'd2);
    beat(8'd12);
    tick();
    tick();
    beat(8'd7);
    chk("stall_acc", acc_out, 19);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_prod = 8'd50;
      #1;
      chk("stall_in_ready", in_ready, 0);
      tick();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_acc_hold", acc_out, 19);
    end
    in_valid = 1'b0;
    release_result();
    chk("stall_released", out_valid, 0);

    // Zero-length run; start in DONE ignored, start with out_ready dropped.
    do_start(8'd0);
    chk("zero_out_valid", out_valid, 1);
    chk("zero_acc", acc_out, 0);
    chk("zero_ovf", ovf, 0);
    do_start(8'd3);
    chk("zero_start_ignored", out_valid, 1);
    chk("zero_acc_unchanged", acc_out, 0);
    start = 1'b1; n_terms = 8'd3; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("zero_start_dropped_busy", busy, 0);
    chk("zero_start_dropped_valid", out_valid, 0);
    tick();
    chk("zero_still_idle", busy, 0);

    // Enable freeze mid-accumulation.
    do_start(8'd4);
    beat(8'd10);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_prod = 8'd100;
      #1;
      chk("ena_in_ready", in_ready, 0);
      tick();
      chk("ena_acc_frozen", acc_out, 10);
      chk("ena_busy", busy, 1);
    end
    ena = 1'b1;
    beat(8'd10);
    beat(8'd10);
    chk("ena_not_done_yet", out_valid, 0);
    beat(8'd10);
    chk("ena_done", out_valid, 1);
    chk("ena_acc", acc_out, 40);
    release_result();

    // Asynchronous reset between clock edges.
    do_start(8'd4);
    beat(8'd50);
    beat(8'd50);
    chk("arst_pre_acc", acc_out, 100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_acc", acc_out, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    tick();
    do_start(8'd1);
    beat(8'd9);
    chk("arst_new_valid", out_valid, 1);
    chk("arst_new_acc", acc_out, 9);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
